// File: rtl/lsu_ahb.sv
// Load/store unit bridging a single-issue RV32 request port to an AHB-Lite master.
// One transfer in flight; completions and exceptions are reported as one-cycle pulses.
module lsu_ahb #(
    parameter int ADDR_W   = 32,
    parameter int WAIT_MAX = 16
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_load,
    input  logic [2:0]        req_funct3,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [4:0]        req_rd,
    input  logic              flush,
    output logic [ADDR_W-1:0] HADDR,
    output logic [1:0]        HTRANS,
    output logic              HWRITE,
    output logic [2:0]        HSIZE,
    output logic [31:0]       HWDATA,
    input  logic [31:0]       HRDATA,
    input  logic              HREADY,
    input  logic              HRESP,
    output logic              rsp_valid,
    output logic [31:0]       rsp_rdata,
    output logic [4:0]        rsp_rd,
    output logic              rsp_wb,
    output logic              exc_valid,
    output logic [1:0]        exc_code
);

    localparam logic [7:0] WAIT_LAST = 8'(WAIT_MAX - 1);

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

    state_t            r_state, w_state_next;
    logic [7:0]        r_wait, w_wait_next;
    logic              r_load, r_hwrite, r_flushed;
    logic [2:0]        r_funct3;
    logic [4:0]        r_rd;
    logic [ADDR_W-1:0] r_haddr;
    logic [31:0]       r_hwdata;
    logic              r_rsp_valid, r_rsp_wb, r_exc_valid;
    logic [31:0]       r_rsp_rdata;
    logic [4:0]        r_rsp_rd;
    logic [1:0]        r_exc_code;

    logic        w_accept, w_illegal, w_misaligned;
    logic        w_done, w_err, w_tmo, w_suppress;
    logic [31:0] w_shifted, w_ld_data, w_wdata_rep;

    assign req_ready = (r_state == S_IDLE) && !flush;
    assign w_accept  = req_valid && req_ready;

    assign w_illegal = req_load ? (req_funct3 == 3'b011 || req_funct3 == 3'b110 || req_funct3 == 3'b111)
                                : (req_funct3 > 3'b010);
    assign w_misaligned = (req_funct3[1:0] == 2'b01 && req_addr[0]) ||
                          (req_funct3[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

    always_comb begin
        w_wdata_rep = req_wdata;
        case (req_funct3[1:0])
            2'b00:   w_wdata_rep = {4{req_wdata[7:0]}};
            2'b01:   w_wdata_rep = {2{req_wdata[15:0]}};
            default: w_wdata_rep = req_wdata;
        endcase
    end

    // Lane select: move the addressed byte/half down to bit 0 before extending.
    assign w_shifted = HRDATA >> {r_haddr[1:0], 3'b000};

    always_comb begin
        w_ld_data = w_shifted;
        case (r_funct3)
            3'b000:  w_ld_data = {{24{w_shifted[7]}}, w_shifted[7:0]};
            3'b001:  w_ld_data = {{16{w_shifted[15]}}, w_shifted[15:0]};
            3'b100:  w_ld_data = {24'd0, w_shifted[7:0]};
            3'b101:  w_ld_data = {16'd0, w_shifted[15:0]};
            default: w_ld_data = w_shifted;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_wait_next  = r_wait;
        w_done       = 1'b0;
        w_err        = 1'b0;
        w_tmo        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_accept && !w_illegal && !w_misaligned) w_state_next = S_ADDR;
            end
            S_ADDR: begin
                if (HREADY) begin
                    w_state_next = S_DATA;
                    w_wait_next  = 8'd0;
                end
            end
            S_DATA: begin
                if (HRESP) begin
                    w_state_next = S_IDLE;
                    w_err        = 1'b1;
                end else if (HREADY) begin
                    w_state_next = S_IDLE;
                    w_done       = 1'b1;
                end else begin
                    w_wait_next = r_wait + 8'd1;
                    if (r_wait == WAIT_LAST) begin
                        w_state_next = S_IDLE;
                        w_tmo        = 1'b1;
                    end
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_state <= S_IDLE;
            r_wait  <= 8'd0;
        end else begin
            r_state <= w_state_next;
            r_wait  <= w_wait_next;
        end
    end

    // A flush seen at any point of an in-flight transfer silences its report.
    assign w_suppress = r_flushed || flush;

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            r_load      <= 1'b0;
            r_hwrite    <= 1'b0;
            r_funct3    <= 3'd0;
            r_rd        <= 5'd0;
            r_haddr     <= '0;
            r_hwdata    <= 32'd0;
            r_flushed   <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_rd    <= 5'd0;
            r_rsp_wb    <= 1'b0;
            r_exc_valid <= 1'b0;
            r_exc_code  <= 2'd0;
        end else begin
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_rd    <= 5'd0;
            r_rsp_wb    <= 1'b0;
            r_exc_valid <= 1'b0;
            if (w_accept) begin
                r_load    <= req_load;
                r_hwrite  <= !req_load;
                r_funct3  <= req_funct3;
                r_rd      <= req_rd;
                r_haddr   <= req_addr;
                r_hwdata  <= w_wdata_rep;
                r_flushed <= 1'b0;
                if (w_illegal) begin
                    r_exc_valid <= 1'b1;
                    r_exc_code  <= 2'b00;
                end else if (w_misaligned) begin
                    r_exc_valid <= 1'b1;
                    r_exc_code  <= 2'b01;
                end
            end else if (r_state != S_IDLE && flush) begin
                r_flushed <= 1'b1;
            end
            if (w_done && !w_suppress) begin
                r_rsp_valid <= 1'b1;
                r_rsp_rdata <= r_load ? w_ld_data : 32'd0;
                r_rsp_rd    <= r_rd;
                r_rsp_wb    <= r_load && (r_rd != 5'd0);
            end
            if ((w_err || w_tmo) && !w_suppress) begin
                r_exc_valid <= 1'b1;
                r_exc_code  <= w_err ? 2'b10 : 2'b11;
            end
        end
    end

    assign HADDR     = r_haddr;
    assign HTRANS    = (r_state == S_ADDR) ? 2'b10 : 2'b00;
    assign HWRITE    = r_hwrite;
    assign HSIZE     = {1'b0, r_funct3[1:0]};
    assign HWDATA    = r_hwdata;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_rd    = r_rsp_rd;
    assign rsp_wb    = r_rsp_wb;
    assign exc_valid = r_exc_valid && !flush;
    assign exc_code  = r_exc_code;

endmodule

// File: tb/tb_lsu_ahb.sv
// Bench for lsu_ahb: hand-computed vector table, directed flush/reset sequences,
// and random requests checked against a rule-level reference model.
module tb_lsu_ahb;

    localparam int WAIT_MAX = 4;

    logic        CLK, RESET;
    logic        req_valid, req_ready, req_load, flush;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic [31:0] HADDR, HWDATA, HRDATA;
    logic [1:0]  HTRANS;
    logic        HWRITE, HREADY, HRESP;
    logic [2:0]  HSIZE;
    logic        rsp_valid, rsp_wb, exc_valid;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic [1:0]  exc_code;

    int total = 0;
    int bad   = 0;

    lsu_ahb #(.ADDR_W(32), .WAIT_MAX(WAIT_MAX)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_valid(req_valid), .req_ready(req_ready), .req_load(req_load),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_rd(req_rd), .flush(flush),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd),
        .rsp_wb(rsp_wb), .exc_valid(exc_valid), .exc_code(exc_code)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        bit        load;
        bit [2:0]  f3;
        bit [31:0] addr;
        bit [31:0] wdata;
        bit [4:0]  rd;
        int        waits;
        bit        err;
        bit [31:0] hrdata;
        bit        exp_exc;
        bit [1:0]  exp_code;
        bit [31:0] exp_rdata;
        bit        exp_wb;
        bit [2:0]  exp_hsize;
        bit [31:0] exp_hwdata;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    function automatic vec_t mkv(bit load, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata,
                                 bit [4:0] rd, int waits, bit err, bit [31:0] hrdata,
                                 bit exc, bit [1:0] code, bit [31:0] rdata, bit wb,
                                 bit [2:0] hsize, bit [31:0] hwdata);
        vec_t v;
        v.load = load; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.rd = rd;
        v.waits = waits; v.err = err; v.hrdata = hrdata;
        v.exp_exc = exc; v.exp_code = code; v.exp_rdata = rdata; v.exp_wb = wb;
        v.exp_hsize = hsize; v.exp_hwdata = hwdata;
        return v;
    endfunction

    // Reference model: outcome derived from access size in bytes and plain arithmetic.
    function automatic vec_t model(bit load, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata,
                                   bit [4:0] rd, int waits, bit err, bit [31:0] hrdata);
        vec_t v;
        int unsigned sz = 1 << f3[1:0];
        bit legal = load ? (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5}) : (f3 <= 3'd2);
        bit [31:0] lane, val;
        v = mkv(load, f3, addr, wdata, rd, waits, err, hrdata, 0, 0, 0, 0, 0, 0);
        v.exp_hsize  = 3'(f3[1:0]);
        v.exp_hwdata = (sz == 1) ? 32'(wdata[7:0]) * 32'h01010101 :
                       (sz == 2) ? 32'(wdata[15:0]) * 32'h00010001 : wdata;
        lane = hrdata >> ((addr % 4) * 8);
        val  = 32'd0;
        if (load) begin
            if (sz == 1) begin
                val = lane & 32'hFF;
                if (!f3[2] && val >= 32'd128) val = val - 32'd256;
            end else if (sz == 2) begin
                val = lane & 32'hFFFF;
                if (!f3[2] && val >= 32'd32768) val = val - 32'd65536;
            end else begin
                val = hrdata;
            end
        end
        if (!legal)                    begin v.exp_exc = 1; v.exp_code = 2'd0; end
        else if (addr % sz != 0)       begin v.exp_exc = 1; v.exp_code = 2'd1; end
        else if (waits >= WAIT_MAX)    begin v.exp_exc = 1; v.exp_code = 2'd3; end
        else if (err)                  begin v.exp_exc = 1; v.exp_code = 2'd2; end
        v.exp_rdata = val;
        v.exp_wb    = load && (rd != 0);
        return v;
    endfunction

    // Called one time unit after a rising edge with the DUT idle; returns in the report cycle.
    task automatic run(input vec_t v, input int id);
        int ndata;
        bit prebus = v.exp_exc && (v.exp_code <= 2'd1);
        $display("txn %0d load=%0b f3=%0d addr=%h wdata=%h rd=%0d waits=%0d err=%0b exc=%0b code=%0d",
                 id, v.load, v.f3, v.addr, v.wdata, v.rd, v.waits, v.err, v.exp_exc, v.exp_code);
        chk($sformatf("t%0d.ready", id), 32'(req_ready), 32'd1);
        req_valid = 1; req_load = v.load; req_funct3 = v.f3; req_addr = v.addr;
        req_wdata = v.wdata; req_rd = v.rd;
        HREADY = 1; HRESP = 0; HRDATA = v.hrdata;
        @(posedge CLK); #1;
        req_valid = 0;
        if (prebus) begin
            chk($sformatf("t%0d.htrans_none", id), 32'(HTRANS), 32'd0);
            chk($sformatf("t%0d.exc_valid", id), 32'(exc_valid), 32'd1);
            chk($sformatf("t%0d.exc_code", id), 32'(exc_code), 32'(v.exp_code));
            chk($sformatf("t%0d.rsp_quiet", id), 32'(rsp_valid), 32'd0);
            return;
        end
        chk($sformatf("t%0d.htrans_addr", id), 32'(HTRANS), 32'd2);
        chk($sformatf("t%0d.haddr", id), HADDR, v.addr);
        chk($sformatf("t%0d.hwrite", id), 32'(HWRITE), 32'(!v.load));
        chk($sformatf("t%0d.hsize", id), 32'(HSIZE), 32'(v.exp_hsize));
        chk($sformatf("t%0d.exc_early", id), 32'(exc_valid), 32'd0);
        ndata = (v.waits >= WAIT_MAX) ? WAIT_MAX : v.waits + 1;
        for (int k = 0; k < ndata; k++) begin
            @(posedge CLK); #1;
            chk($sformatf("t%0d.htrans_data%0d", id, k), 32'(HTRANS), 32'd0);
            chk($sformatf("t%0d.pulse_early%0d", id, k), 32'({rsp_valid, exc_valid}), 32'd0);
            if (!v.load) chk($sformatf("t%0d.hwdata%0d", id, k), HWDATA, v.exp_hwdata);
            HREADY = (k < v.waits) ? 1'b0 : 1'b1;
            HRESP  = (k >= v.waits) ? v.err : 1'b0;
        end
        @(posedge CLK); #1;
        HREADY = 1; HRESP = 0;
        chk($sformatf("t%0d.rsp_valid", id), 32'(rsp_valid), 32'(!v.exp_exc));
        chk($sformatf("t%0d.exc_valid", id), 32'(exc_valid), 32'(v.exp_exc));
        chk($sformatf("t%0d.ready_after", id), 32'(req_ready), 32'd1);
        if (v.exp_exc) begin
            chk($sformatf("t%0d.exc_code", id), 32'(exc_code), 32'(v.exp_code));
        end else begin
            chk($sformatf("t%0d.rdata", id), rsp_rdata, v.exp_rdata);
            chk($sformatf("t%0d.rsp_rd", id), 32'(rsp_rd), 32'(v.rd));
            chk($sformatf("t%0d.rsp_wb", id), 32'(rsp_wb), 32'(v.exp_wb));
        end
    endtask

    vec_t tbl[18];
    vec_t rv;

    initial begin
        RESET = 0; req_valid = 0; req_load = 0; req_funct3 = 0; req_addr = 0;
        req_wdata = 0; req_rd = 0; flush = 0; HRDATA = 0; HREADY = 1; HRESP = 0;

        tbl[0]  = mkv(1, 3'd2, 32'h100, 0, 5, 0, 0, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 1, 3'd2, 0);
        tbl[1]  = mkv(1, 3'd0, 32'h103, 0, 7, 0, 0, 32'h80FF0000, 0, 0, 32'hFFFFFF80, 1, 3'd0, 0);
        tbl[2]  = mkv(1, 3'd4, 32'h103, 0, 7, 1, 0, 32'h80FF0000, 0, 0, 32'h00000080, 1, 3'd0, 0);
        tbl[3]  = mkv(0, 3'd1, 32'h202, 32'h1234ABCD, 9, 3, 0, 0, 0, 0, 0, 0, 3'd1, 32'hABCDABCD);
        tbl[4]  = mkv(1, 3'd2, 32'h101, 0, 5, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0);
        tbl[5]  = mkv(1, 3'd2, 32'h200, 0, 5, 0, 1, 0, 1, 2'd2, 0, 0, 3'd2, 0);
        tbl[6]  = mkv(1, 3'd2, 32'h300, 0, 5, 6, 0, 0, 1, 2'd3, 0, 0, 3'd2, 0);
        tbl[7]  = mkv(1, 3'd3, 32'h100, 0, 5, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0);
        tbl[8]  = mkv(0, 3'd4, 32'h100, 0, 5, 0, 0, 0, 1, 2'd0, 0, 0, 0, 0);
        tbl[9]  = mkv(1, 3'd1, 32'h102, 0, 4, 0, 0, 32'h80011234, 0, 0, 32'hFFFF8001, 1, 3'd1, 0);
        tbl[10] = mkv(1, 3'd5, 32'h102, 0, 4, 0, 0, 32'h80011234, 0, 0, 32'h00008001, 1, 3'd1, 0);
        tbl[11] = mkv(0, 3'd0, 32'h105, 32'h000000A5, 2, 2, 0, 0, 0, 0, 0, 0, 3'd0, 32'hA5A5A5A5);
        tbl[12] = mkv(0, 3'd2, 32'h010, 32'h11223344, 0, 0, 0, 0, 0, 0, 0, 0, 3'd2, 32'h11223344);
        tbl[13] = mkv(1, 3'd2, 32'h104, 0, 0, 0, 0, 32'hCAFEF00D, 0, 0, 32'hCAFEF00D, 0, 3'd2, 0);
        tbl[14] = mkv(1, 3'd1, 32'h101, 0, 3, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0);
        tbl[15] = mkv(0, 3'd2, 32'h102, 0, 3, 0, 0, 0, 1, 2'd1, 0, 0, 0, 0);
        tbl[16] = mkv(1, 3'd0, 32'h101, 0, 1, 0, 0, 32'h00007F00, 0, 0, 32'h0000007F, 1, 3'd0, 0);
        tbl[17] = mkv(0, 3'd2, 32'h400, 32'h1, 3, 1, 1, 0, 1, 2'd2, 0, 0, 3'd2, 32'h1);

        #3;
        chk("rst.htrans", 32'(HTRANS), 32'd0);
        chk("rst.hwrite", 32'(HWRITE), 32'd0);
        chk("rst.haddr", HADDR, 32'd0);
        chk("rst.hsize", 32'(HSIZE), 32'd0);
        chk("rst.hwdata", HWDATA, 32'd0);
        chk("rst.pulses", 32'({rsp_valid, exc_valid}), 32'd0);
        #5 RESET = 1;

        // First edge after release accepts the first table entry.
        for (int i = 0; i < 18; i++) run(tbl[i], i);

        // Flush while idle: request must be ignored.
        flush = 1; req_valid = 1; req_load = 1; req_funct3 = 3'd2; req_addr = 32'h40;
        #0 chk("fidle.ready", 32'(req_ready), 32'd0);
        @(posedge CLK); #1;
        chk("fidle.htrans", 32'(HTRANS), 32'd0);
        flush = 0; req_valid = 0;
        @(posedge CLK); #1;
        chk("fidle.no_exc", 32'({rsp_valid, exc_valid}), 32'd0);

        // Flush during DATA: transfer completes but its response is dropped.
        req_valid = 1; req_load = 1; req_funct3 = 3'd2; req_addr = 32'h44; req_rd = 5'd3;
        HRDATA = 32'h12345678;
        @(posedge CLK); #1;
        req_valid = 0;
        chk("fdata.htrans_addr", 32'(HTRANS), 32'd2);
        @(posedge CLK); #1;
        flush = 1; HREADY = 0;
        @(posedge CLK); #1;
        flush = 0; HREADY = 1;
        chk("fdata.still_data", 32'({HTRANS, req_ready}), 32'd0);
        @(posedge CLK); #1;
        chk("fdata.no_pulse", 32'({rsp_valid, exc_valid}), 32'd0);
        chk("fdata.ready", 32'(req_ready), 32'd1);

        // Flush in ADDR then bus error: exception dropped.
        req_valid = 1; req_load = 0; req_funct3 = 3'd2; req_addr = 32'h48;
        @(posedge CLK); #1;
        req_valid = 0; flush = 1;
        @(posedge CLK); #1;
        flush = 0; HRESP = 1;
        @(posedge CLK); #1;
        HRESP = 0;
        chk("ferr.no_pulse", 32'({rsp_valid, exc_valid}), 32'd0);

        // Pending pre-bus exception masked by flush in its pulse cycle.
        req_valid = 1; req_load = 1; req_funct3 = 3'd7; req_addr = 32'h0;
        @(posedge CLK); #1;
        req_valid = 0;
        chk("fexc.visible", 32'(exc_valid), 32'd1);
        flush = 1; #1;
        chk("fexc.masked", 32'(exc_valid), 32'd0);
        @(posedge CLK); #1;
        flush = 0;

        // Reset pulsed mid-ADDR: bus returns to IDLE immediately, nothing reported.
        req_valid = 1; req_load = 0; req_funct3 = 3'd2; req_addr = 32'h80; req_wdata = 32'h55AA55AA;
        @(posedge CLK); #1;
        req_valid = 0;
        chk("rmid.htrans_addr", 32'(HTRANS), 32'd2);
        RESET = 0; #1;
        chk("rmid.htrans", 32'(HTRANS), 32'd0);
        chk("rmid.haddr", HADDR, 32'd0);
        chk("rmid.hwdata", HWDATA, 32'd0);
        chk("rmid.hwrite", 32'(HWRITE), 32'd0);
        #1 RESET = 1;
        run(tbl[0], 50);

        // Randomized requests against the reference model.
        for (int i = 0; i < 150; i++) begin
            rv = model($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)),
                       32'($urandom_range(0, 32'hFFFF)), $urandom, 5'($urandom_range(0, 31)),
                       $urandom_range(0, 5), $urandom_range(0, 7) == 0, $urandom);
            run(rv, 100 + i);
        end

        @(posedge CLK); #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lsu_ahb.md
LSU_AHB -- requirements
Module: lsu_ahb

Interface
REQ-001 Parameter ADDR_W, 32, byte-address width of request and HADDR.
REQ-002 Parameter WAIT_MAX, 16, maximum HREADY-low data-phase cycles before timeout; range 1..255.
REQ-003 CLK  in  1  clock, all state on rising edge.
REQ-004 RESET  in  1  reset, asynchronous, active-low.
REQ-005 req_valid  in  1  request present.
REQ-006 req_ready  out  1  block can accept a request.
REQ-007 req_load  in  1  1 = load, 0 = store.
REQ-008 req_funct3  in  3  RV32 funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
REQ-009 req_addr  in  ADDR_W  byte address.
REQ-010 req_wdata  in  32  store data, low bits significant.
REQ-011 req_rd  in  5  destination register.
REQ-012 flush  in  1  discard current and incoming work.
REQ-013 HADDR  out  ADDR_W  AHB-Lite address.
REQ-014 HTRANS  out  2  AHB-Lite: 00 IDLE or 10 NONSEQ only.
REQ-015 HWRITE  out  1  write transfer.
REQ-016 HSIZE  out  3  transfer size {0, funct3[1:0]}.
REQ-017 HWDATA  out  32  write data.
REQ-018 HRDATA  in  32  read data.
REQ-019 HREADY  in  1  transfer ready.
REQ-020 HRESP  in  1  error response.
REQ-021 rsp_valid  out  1  one-cycle completion pulse.
REQ-022 rsp_rdata  out  32  extended load data (0 for stores).
REQ-023 rsp_rd  out  5  destination register of completion.
REQ-024 rsp_wb  out  1  write-back enable: load AND rd != 0.
REQ-025 exc_valid  out  1  one-cycle exception pulse.
REQ-026 exc_code  out  2  00 illegal funct3, 01 misaligned, 10 bus error, 11 timeout.

Function
REQ-027 FSM states IDLE, ADDR, DATA; req_ready SHALL be 1 exactly in IDLE with flush = 0.
REQ-028 Accept on rising edge with req_valid && req_ready; all request fields registered.
REQ-029 Illegal funct3 (load 011/110/111, store above 010): no bus transfer; stay IDLE; next cycle exc_valid = 1, code 00.
REQ-030 Misaligned (halfword addr[0] = 1, word addr[1:0] != 0): no bus transfer; stay IDLE; next cycle exc_valid = 1, code 01.
REQ-031 Legal accept -> ADDR: HTRANS = 10, HADDR = full byte address, HWRITE = !req_load, HSIZE per REQ-016; held until sampled HREADY = 1, then -> DATA.
REQ-032 DATA: HTRANS = 00; stores drive HWDATA lane-replicated (byte {4{b}}, half {2{h}}, word as-is), held stable for the whole phase.
REQ-033 DATA completes on HREADY = 1 && HRESP = 0 -> IDLE; next cycle rsp_valid = 1 with rsp_rd, rsp_wb, rsp_rdata.
REQ-034 Load extraction: lane selected by addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW raw.
REQ-035 HRESP = 1 in DATA -> IDLE; next cycle exc_valid = 1, code 10; rsp_valid = 0.
REQ-036 Wait counter cleared on DATA entry, incremented per HREADY-low cycle; reaching WAIT_MAX -> IDLE, HTRANS = 00; next cycle exc_valid = 1, code 11.
REQ-037 Zero-wait latency: accept edge N, ADDR cycle N+1, DATA cycle N+2, rsp_valid cycle N+3; a new request may be accepted in the rsp_valid cycle.
REQ-038 Flush in ADDR/DATA: bus transfer still runs to completion, error or timeout; its rsp_valid and exc_valid are suppressed.
REQ-039 Flush in IDLE: req_valid ignored; any pending exception pulse is suppressed.
REQ-040 rsp_valid and exc_valid SHALL never be 1 in the same cycle.

Reset
REQ-041 RESET low: state IDLE, HTRANS = 00, HWRITE = 0, HADDR/HSIZE/HWDATA = 0, rsp_*/exc_* = 0, wait counter = 0, effective immediately, including mid-transfer.
REQ-042 First rising edge after RESET release may accept a request.

Verification
REQ-043 LW at 0x100, HREADY = 1, HRDATA = 0xDEADBEEF, rd = 5 -> HTRANS 10 at N+1, rsp_valid at N+3, rsp_rdata 0xDEADBEEF, rsp_wb = 1.
REQ-044 LB at 0x103, HRDATA = 0x80FF_0000 -> rsp_rdata 0xFFFFFF80; LBU at 0x103 -> 0x00000080.
REQ-045 SH at 0x202, wdata 0x1234ABCD -> HSIZE 001, HADDR 0x202, HWDATA 0xABCDABCD; 3 HREADY-low cycles -> rsp_valid, rsp_wb = 0.
REQ-046 LW at 0x101 -> no NONSEQ issued, exc_valid code 01 next cycle; DATA with HRESP = 1 -> exc code 10.
REQ-047 WAIT_MAX = 4, HREADY held low -> exc code 11 after 4 DATA cycles, state IDLE, req_ready = 1.
REQ-048 Flush asserted during DATA, and RESET pulsed mid-ADDR -> no rsp_valid/exc_valid for that transfer; HTRANS = 00 immediately on reset.
